// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: single outstanding req/ack bus transfer with
// alignment checking, store lane steering and load data right-alignment.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        fault,
  output logic [1:0]  faultCause,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busBe,
  output logic [31:0] busWdata,
  input  logic        busAck,
  input  logic        busErr,
  input  logic [31:0] busRdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_isLoad;
  logic [1:0]  r_off;
  logic        r_busReq;
  logic        r_busWe;
  logic [31:0] r_busAddr;
  logic [3:0]  r_busBe;
  logic [31:0] r_busWdata;
  logic [31:0] r_loadData;
  logic [1:0]  r_faultCause;

  logic        w_req;
  logic        w_illegal;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_req     = memRead | memWrite;
    w_illegal = 1'b0;
    case (funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = addr[0];
      3'b010:  w_illegal = (addr[1:0] != 2'b00);
      3'b100:  w_illegal = memWrite;
      3'b101:  w_illegal = memWrite | addr[0];
      default: w_illegal = 1'b1;
    endcase

    w_be    = 4'b1111;
    w_wdata = storeData;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{storeData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{storeData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = storeData;
      end
    endcase

    w_tmo  = (r_cnt == TMO_LAST);
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_illegal ? FAULT : REQ;
      REQ: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (busAck)     w_next = busErr ? FAULT : DONE;
        else if (w_tmo) w_next = FAULT;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_isLoad     <= 1'b0;
      r_off        <= '0;
      r_busReq     <= 1'b0;
      r_busWe      <= 1'b0;
      r_busAddr    <= '0;
      r_busBe      <= '0;
      r_busWdata   <= '0;
      r_loadData   <= '0;
      r_faultCause <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_illegal) begin
              r_faultCause <= 2'b01;
            end else begin
              r_busReq   <= 1'b1;
              r_busWe    <= memWrite;
              r_busAddr  <= {addr[31:2], 2'b00};
              r_busBe    <= w_be;
              r_busWdata <= w_wdata;
              r_isLoad   <= ~memWrite;
              r_off      <= addr[1:0];
              r_cnt      <= '0;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (busAck) begin
            r_busReq <= 1'b0;
            if (busErr)        r_faultCause <= 2'b10;
            else if (r_isLoad) r_loadData   <= busRdata >> {r_off, 3'b000};
          end else if (w_tmo) begin
            r_busReq     <= 1'b0;
            r_faultCause <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so every output reads 0 while rst_n is low.
  assign stall      = rst_n & (((r_state == IDLE) & w_req) | (r_state == REQ));
  assign loadValid  = (r_state == DONE) & r_isLoad;
  assign fault      = (r_state == FAULT);
  assign faultCause = r_faultCause;
  assign loadData   = r_loadData;
  assign busReq     = r_busReq;
  assign busWe      = r_busWe;
  assign busAddr    = r_busAddr;
  assign busBe      = r_busBe;
  assign busWdata   = r_busWdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: transaction-level reference model with a
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_lsu_mem_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid, fault;
  logic [1:0]  faultCause;
  logic        busReq, busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busAck, busErr;
  logic [31:0] busRdata;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .addr(addr), .storeData(storeData), .stall(stall),
    .loadData(loadData), .loadValid(loadValid), .fault(fault),
    .faultCause(faultCause), .busReq(busReq), .busWe(busWe),
    .busAddr(busAddr), .busBe(busBe), .busWdata(busWdata),
    .busAck(busAck), .busErr(busErr), .busRdata(busRdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic        chk_en = 1'b0;
  logic        e_stall, e_busReq, e_loadValid, e_fault, e_chkBus, e_busWe;
  logic [31:0] e_busAddr, e_busWdata;
  logic [3:0]  e_busBe;
  logic [31:0] m_ld;
  logic [1:0]  m_fc;
  int          n_req_hi;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("stall",      32'(stall),      32'(e_stall));
      chk("busReq",     32'(busReq),     32'(e_busReq));
      chk("loadValid",  32'(loadValid),  32'(e_loadValid));
      chk("fault",      32'(fault),      32'(e_fault));
      chk("faultCause", 32'(faultCause), 32'(m_fc));
      chk("loadData",   loadData,        m_ld);
      if (e_chkBus) begin
        chk("busWe",   32'(busWe),  32'(e_busWe));
        chk("busAddr", busAddr,     e_busAddr);
        chk("busBe",   32'(busBe),  32'(e_busBe));
        if (e_busWe) chk("busWdata", busWdata, e_busWdata);
      end
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic ok_type;
    if (wr) ok_type = f3 inside {3'd0, 3'd1, 3'd2};
    else    ok_type = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return ok_type && ((int'(a[1:0]) % size_of(f3)) == 0);
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_of(f3)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = size_of(f3);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    n_req_hi += int'(busReq);
  endtask

  task automatic set_exp(input logic s, input logic r, input logic lv, input logic f);
    e_stall = s; e_busReq = r; e_loadValid = lv; e_fault = f; e_chkBus = 1'b0;
  endtask

  task automatic rand_tail();
    memRead   = 1'($urandom_range(0, 1));
    memWrite  = 1'($urandom_range(0, 1));
    funct3    = 3'($urandom);
    addr      = $urandom;
    storeData = $urandom;
    busAck    = 1'($urandom_range(0, 1));
    busErr    = 1'($urandom_range(0, 1));
    busRdata  = $urandom;
  endtask

  task automatic idle_cycle(input logic ack);
    next_cycle();
    memRead = 1'b0; memWrite = 1'b0;
    funct3 = 3'($urandom); addr = $urandom; storeData = $urandom;
    busAck = ack; busErr = 1'($urandom_range(0, 1)); busRdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    sample();
  endtask

  // One whole access; ackd is the REQ cycle index carrying the ack (>= TO or <0: none).
  task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int ackd, input logic err);
    logic acked;
    logic isld;
    isld  = ~wr;
    acked = 1'b0;
    n_req_hi = 0;
    next_cycle();
    memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd;
    busAck = 1'($urandom_range(0, 1)); busErr = 1'($urandom_range(0, 1)); busRdata = $urandom;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    if (!legal(wr, f3, a)) begin
      next_cycle();
      rand_tail();
      m_fc = 2'b01;
      set_exp(1'b0, 1'b0, 1'b0, 1'b1);
      sample();
      return;
    end
    for (int k = 0; k < int'(TO); k++) begin
      next_cycle();
      acked    = (k == ackd);
      busAck   = acked;
      busErr   = acked ? err : 1'($urandom_range(0, 1));
      busRdata = acked ? rdata : $urandom;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0);
      e_chkBus   = 1'b1;
      e_busWe    = wr;
      e_busAddr  = {a[31:2], 2'b00};
      e_busBe    = be_of(f3, a);
      e_busWdata = wdata_of(f3, sd);
      sample();
      if (k == 0) begin
        obs_addr = busAddr; obs_be = busBe; obs_wdata = busWdata; obs_we = busWe;
      end
      if (acked) break;
    end
    next_cycle();
    rand_tail();
    if (acked && !err) begin
      if (isld) m_ld = rdata >> (8 * int'(a[1:0]));
      set_exp(1'b0, 1'b0, isld, 1'b0);
    end else begin
      m_fc = acked ? 2'b10 : 2'b11;
      set_exp(1'b0, 1'b0, 1'b0, 1'b1);
    end
    sample();
  endtask

  initial begin
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = '0; addr = '0;
    storeData = '0; busAck = 1'b0; busErr = 1'b0; busRdata = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    e_busWe = 1'b0; e_busAddr = '0; e_busBe = '0; e_busWdata = '0;
    m_ld = '0; m_fc = '0; n_req_hi = 0;
    #12;
    chk("rst_busReq",  32'(busReq),     32'd0);
    chk("rst_stall",   32'(stall),      32'd0);
    chk("rst_loadData", loadData,       32'd0);
    chk("rst_fault",   32'(fault),      32'd0);
    chk("rst_cause",   32'(faultCause), 32'd0);
    chk("rst_busBe",   32'(busBe),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_en = 1'b1;

    // LB at 0x1003, ack in the first REQ cycle.
    do_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h1234_5678, 32'h80FF_1234, 0, 1'b0);
    chk("lb_busAddr", obs_addr, 32'h0000_1000);
    chk("lb_busBe",   32'(obs_be), 32'h8);
    chk("lb_loadData", loadData, 32'h0000_0080);
    chk("lb_loadValid", 32'(loadValid), 32'd1);
    chk("lb_reqCycles", 32'(n_req_hi), 32'd1);
    idle_cycle(1'b1);

    // SH at 0x2002, ack after 3 wait cycles (coincides with the timeout limit).
    do_txn(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
    chk("sh_busWe",    32'(obs_we), 32'd1);
    chk("sh_busBe",    32'(obs_be), 32'hC);
    chk("sh_busWdata", obs_wdata, 32'hBEEF_BEEF);
    chk("sh_reqCycles", 32'(n_req_hi), 32'd4);
    chk("sh_loadValid", 32'(loadValid), 32'd0);
    chk("sh_fault",     32'(fault), 32'd0);

    // Misaligned LW and illegal store funct3.
    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0005, 32'h0, 32'h0, 0, 1'b0);
    chk("lw_mis_fault", 32'(fault), 32'd1);
    chk("lw_mis_cause", 32'(faultCause), 32'd1);
    chk("lw_mis_req",   32'(n_req_hi), 32'd0);
    idle_cycle(1'b0);
    do_txn(1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'h55, 32'h0, 0, 1'b0);
    chk("sb100_fault", 32'(fault), 32'd1);
    chk("sb100_cause", 32'(faultCause), 32'd1);
    chk("sb100_req",   32'(n_req_hi), 32'd0);

    // LHU with bus error: loadData keeps 0x80.
    do_txn(1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 1, 1'b1);
    chk("lhu_err_cause", 32'(faultCause), 32'd2);
    chk("lhu_err_ld",    loadData, 32'h0000_0080);
    chk("lhu_err_lv",    32'(loadValid), 32'd0);

    // Timeout, then a late ack that must be ignored.
    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0, -1, 1'b0);
    chk("tmo_reqCycles", 32'(n_req_hi), 32'd4);
    chk("tmo_fault",     32'(fault), 32'd1);
    chk("tmo_cause",     32'(faultCause), 32'd3);
    idle_cycle(1'b1);
    chk("tmo_lateack_req", 32'(busReq), 32'd0);
    chk("tmo_lateack_flt", 32'(fault), 32'd0);

    // Asynchronous reset in the middle of a REQ.
    next_cycle();
    memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h100; busAck = 1'b0; busErr = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    next_cycle();
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    e_chkBus = 1'b1; e_busWe = 1'b0; e_busAddr = 32'h100; e_busBe = 4'hF;
    sample();
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    busAck = 1'b1;
    #1;
    chk("arst_busReq", 32'(busReq), 32'd0);
    chk("arst_stall",  32'(stall),  32'd0);
    chk("arst_ld",     loadData,    32'd0);
    chk("arst_cause",  32'(faultCause), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    memRead = 1'b0;
    m_ld = '0; m_fc = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_en = 1'b1;
    idle_cycle(1'b1);
    do_txn(1'b1, 1'b0, 3'b100, 32'h0, 32'h0, 32'h0000_00AA, 0, 1'b0);
    chk("post_rst_lbu", loadData, 32'h0000_00AA);
    chk("post_rst_lv",  32'(loadValid), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic rd, wr;
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
      sel = int'($urandom_range(0, 2));
      rd  = (sel != 1);
      wr  = (sel != 0);
      do_txn(rd, wr, 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, TO)), ($urandom_range(0, 3) == 0));
    end
    idle_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
